// File: rtl/pic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pic_pkg
// Brief    : Register addresses, command codes, read selects and FSM states
//            shared by the interrupt-controller core and its resolver.
// Revision : 1.0
// ============================================================================
package pic_pkg;

    localparam logic [1:0] ADDR_INIT = 2'd0;
    localparam logic [1:0] ADDR_IMR  = 2'd1;
    localparam logic [1:0] ADDR_CMD  = 2'd2;
    localparam logic [1:0] ADDR_MODE = 2'd3;

    localparam logic [2:0] OP_ROT_AEOI_CLR = 3'b000;
    localparam logic [2:0] OP_NS_EOI       = 3'b001;
    localparam logic [2:0] OP_NOP          = 3'b010;
    localparam logic [2:0] OP_S_EOI        = 3'b011;
    localparam logic [2:0] OP_ROT_AEOI_SET = 3'b100;
    localparam logic [2:0] OP_ROT_NS_EOI   = 3'b101;
    localparam logic [2:0] OP_SET_PRIO     = 3'b110;
    localparam logic [2:0] OP_ROT_S_EOI    = 3'b111;

    localparam logic [1:0] RSEL_IRR = 2'b10;
    localparam logic [1:0] RSEL_ISR = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACK1 = 2'd1;
    localparam logic [1:0] ST_ACK2 = 2'd2;

    // Rank 0 is the channel just after the lowest-priority pointer.
    function automatic int prio_rank(input int id, input int ptr, input int n);
        return (id - ptr - 1 + 2 * n) % n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pic_ctrl_core_if.sv
`default_nettype none
// ============================================================================
// Module   : pic_ctrl_core_if
// Brief    : CPU register bus plus interrupt-acknowledge handshake.
// Revision : 1.0
// ============================================================================
interface pic_ctrl_core_if #(
    parameter int DATA_W = 16,
    parameter int VEC_W  = 8
);
    logic              wr_en;
    logic              rd_en;
    logic [1:0]        addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              inta_n;
    logic              int_out;
    logic [VEC_W-1:0]  vec_out;
    logic              vec_valid;

    modport master (
        output wr_en, rd_en, addr, wdata, inta_n,
        input  rdata, int_out, vec_out, vec_valid
    );

    modport slave (
        input  wr_en, rd_en, addr, wdata, inta_n,
        output rdata, int_out, vec_out, vec_valid
    );
endinterface
`default_nettype wire

// File: rtl/pic_priority_resolver.sv
`default_nettype none
// ============================================================================
// Module   : pic_priority_resolver
// Brief    : Rotating-priority picker: highest set request after the pointer.
// Revision : 1.0
// ============================================================================
module pic_priority_resolver #(
    parameter int NUM_IRQ = 8,
    parameter int ID_W    = $clog2(NUM_IRQ)
) (
    input  wire logic [NUM_IRQ-1:0] req,
    input  wire logic [ID_W-1:0]    ptr,
    output logic                    valid,
    output logic [ID_W-1:0]         id
);

    // Walk from lowest to highest rank so the last hit is the winner.
    always_comb begin
        int idx;
        idx   = 0;
        valid = 1'b0;
        id    = '0;
        for (int k = NUM_IRQ; k >= 1; k--) begin
            idx = (int'(ptr) + k) % NUM_IRQ;
            if (req[idx[ID_W-1:0]]) begin
                valid = 1'b1;
                id    = idx[ID_W-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pic_ctrl_core.sv
`default_nettype none
// ============================================================================
// Module   : pic_ctrl_core
// Brief    : 8259-style interrupt controller core for NUM_IRQ channels.
// Revision : 1.0
// ============================================================================
module pic_ctrl_core
    import pic_pkg::*;
#(
    parameter int NUM_IRQ = 8,
    parameter int DATA_W  = 16,
    parameter int VEC_W   = 8,
    parameter int ID_W    = $clog2(NUM_IRQ)
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    input  wire logic [NUM_IRQ-1:0] irq_in,
    pic_ctrl_core_if.slave          bus
);

    logic [NUM_IRQ-1:0]    irr_q, irr_d, isr_q, isr_d, imr_q, imr_d, irq_prev_q;
    logic [VEC_W-ID_W-1:0] base_q, base_d;
    logic [ID_W-1:0]       ptr_q, ptr_d, id_q, id_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic [VEC_W-1:0]      vec_out_q, vec_out_d;
    logic [1:0]            read_sel_q, read_sel_d, state_q, state_d;
    logic int_out_q, int_out_d, vec_valid_q, vec_valid_d, spurious_q, spurious_d;
    logic ltim_q, ltim_d, aeoi_q, aeoi_d, rot_aeoi_q, rot_aeoi_d, inta_q;

    logic                  w_pend_valid, w_isr_valid, w_ack1_go, w_ack2_go;
    logic [ID_W-1:0]       w_pend_id, w_isr_id, w_cmd_id;
    logic [NUM_IRQ-1:0]    w_pend_req, w_grant_mask, w_irq_rise;
    logic                  w_inta_fall, w_inta_rise, w_init_wr, w_cmd_wr, w_unused_ok;
    logic [2:0]            w_op;

    assign w_pend_req  = irr_q & ~imr_q;
    assign w_irq_rise  = irq_in & ~irq_prev_q;
    assign w_inta_fall = inta_q & ~bus.inta_n;
    assign w_inta_rise = ~inta_q & bus.inta_n;
    assign w_init_wr   = bus.wr_en && (bus.addr == ADDR_INIT);
    assign w_cmd_wr    = bus.wr_en && (bus.addr == ADDR_CMD);
    assign w_op        = bus.wdata[7:5];
    assign w_cmd_id    = bus.wdata[ID_W-1:0];
    assign w_unused_ok = &{1'b0, bus.wdata};
    assign w_grant_mask = (w_ack1_go && w_pend_valid) ? (NUM_IRQ'(1) << w_pend_id) : '0;

    pic_priority_resolver #(.NUM_IRQ(NUM_IRQ), .ID_W(ID_W)) u_pend_res (
        .req(w_pend_req), .ptr(ptr_q), .valid(w_pend_valid), .id(w_pend_id)
    );

    pic_priority_resolver #(.NUM_IRQ(NUM_IRQ), .ID_W(ID_W)) u_isr_res (
        .req(isr_q), .ptr(ptr_q), .valid(w_isr_valid), .id(w_isr_id)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (w_inta_fall) state_d = ST_ACK1;
            ST_ACK1: if (w_inta_fall) state_d = ST_ACK2;
            ST_ACK2: if (w_inta_rise) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (w_init_wr) state_d = ST_IDLE;
    end

    // An init write in the same cycle as an acknowledge edge aborts the sequence.
    always_comb begin
        w_ack1_go = (state_q == ST_IDLE) && w_inta_fall && !w_init_wr;
        w_ack2_go = (state_q == ST_ACK1) && w_inta_fall && !w_init_wr;
    end

    always_comb begin
        irr_d = irr_q;  isr_d = isr_q;  imr_d = imr_q;  base_d = base_q;  ptr_d = ptr_q;
        ltim_d = ltim_q;  aeoi_d = aeoi_q;  rot_aeoi_d = rot_aeoi_q;  read_sel_d = read_sel_q;
        rdata_d = rdata_q;  vec_out_d = vec_out_q;  vec_valid_d = w_ack2_go;
        id_d = id_q;  spurious_d = spurious_q;  int_out_d = 1'b0;

        if (ltim_q) irr_d = irq_in;
        else        irr_d = (irr_q & ~w_grant_mask) | w_irq_rise;

        if (w_cmd_wr) begin
            case (w_op)
                OP_NS_EOI:       if (w_isr_valid) isr_d[w_isr_id] = 1'b0;
                OP_ROT_NS_EOI:   if (w_isr_valid) begin
                                     isr_d[w_isr_id] = 1'b0;
                                     ptr_d = w_isr_id;
                                 end
                OP_S_EOI:        if (int'(w_cmd_id) < NUM_IRQ) isr_d[w_cmd_id] = 1'b0;
                OP_ROT_S_EOI:    if (int'(w_cmd_id) < NUM_IRQ) begin
                                     isr_d[w_cmd_id] = 1'b0;
                                     ptr_d = w_cmd_id;
                                 end
                OP_SET_PRIO:     if (int'(w_cmd_id) < NUM_IRQ) ptr_d = w_cmd_id;
                OP_ROT_AEOI_SET: rot_aeoi_d = 1'b1;
                OP_ROT_AEOI_CLR: rot_aeoi_d = 1'b0;
                default:         ;
            endcase
        end

        // Grant is applied after any EOI so a same-bit set wins.
        if (w_ack1_go) begin
            id_d       = w_pend_valid ? w_pend_id : ID_W'(NUM_IRQ - 1);
            spurious_d = ~w_pend_valid;
        end
        isr_d = isr_d | w_grant_mask;

        if (w_ack2_go) begin
            vec_out_d = {base_q, id_q};
            if (aeoi_q && !spurious_q) begin
                isr_d[id_q] = 1'b0;
                if (rot_aeoi_q) ptr_d = id_q;
            end
        end

        if (bus.wr_en && bus.addr == ADDR_IMR) imr_d = bus.wdata[NUM_IRQ-1:0];
        if (bus.wr_en && bus.addr == ADDR_MODE) begin
            ltim_d     = bus.wdata[0];
            aeoi_d     = bus.wdata[1];
            read_sel_d = bus.wdata[3:2];
        end

        if (bus.rd_en) begin
            if (bus.addr == ADDR_IMR)        rdata_d = DATA_W'(imr_q);
            else if (read_sel_q == RSEL_ISR) rdata_d = DATA_W'(isr_q);
            else                             rdata_d = DATA_W'(irr_q);
        end

        if (!w_ack1_go && w_pend_valid)
            int_out_d = !w_isr_valid ||
                        (prio_rank(int'(w_pend_id), int'(ptr_q), NUM_IRQ) <
                         prio_rank(int'(w_isr_id),  int'(ptr_q), NUM_IRQ));

        if (w_init_wr) begin
            base_d     = bus.wdata[VEC_W-1:ID_W];
            irr_d      = '0;
            isr_d      = '0;
            imr_d      = '0;
            rot_aeoi_d = 1'b0;
            ptr_d      = ID_W'(NUM_IRQ - 1);
            int_out_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irr_q <= '0;  isr_q <= '0;  imr_q <= '0;  irq_prev_q <= '0;  base_q <= '0;
            ptr_q <= ID_W'(NUM_IRQ - 1);  id_q <= '0;  rdata_q <= '0;  vec_out_q <= '0;
            read_sel_q <= RSEL_IRR;  int_out_q <= 1'b0;  vec_valid_q <= 1'b0;
            spurious_q <= 1'b0;  ltim_q <= 1'b0;  aeoi_q <= 1'b0;  rot_aeoi_q <= 1'b0;
            inta_q <= 1'b1;
        end else begin
            irr_q <= irr_d;  isr_q <= isr_d;  imr_q <= imr_d;  irq_prev_q <= irq_in;
            base_q <= base_d;  ptr_q <= ptr_d;  id_q <= id_d;  rdata_q <= rdata_d;
            vec_out_q <= vec_out_d;  read_sel_q <= read_sel_d;  int_out_q <= int_out_d;
            vec_valid_q <= vec_valid_d;  spurious_q <= spurious_d;  ltim_q <= ltim_d;
            aeoi_q <= aeoi_d;  rot_aeoi_q <= rot_aeoi_d;  inta_q <= bus.inta_n;
        end
    end

    assign bus.rdata     = rdata_q;
    assign bus.int_out   = int_out_q;
    assign bus.vec_out   = vec_out_q;
    assign bus.vec_valid = vec_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_pic_ctrl_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_pic_ctrl_core
// Brief    : Directed scenarios plus random traffic against a channel-array model.
// Revision : 1.0
// ============================================================================
module tb_pic_ctrl_core;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] irq_in = '0;

    pic_ctrl_core_if #(.DATA_W(16), .VEC_W(8)) bus_if ();

    pic_ctrl_core #(.NUM_IRQ(N), .DATA_W(16), .VEC_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .bus(bus_if)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int vec_cnt = 0;
    logic [7:0] last_vec = '0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: plain bit-vectors, channel numbers and a stage counter.
    logic [7:0]  m_irr, m_isr, m_imr, m_prev, m_vec;
    logic [15:0] m_rdata;
    logic [4:0]  m_base;
    logic [1:0]  m_rsel;
    int          m_ptr, m_stage, m_gid;
    bit          m_spur, m_ltim, m_aeoi, m_rot, m_inta_prev, m_int, m_vv;

    function automatic int top_of(logic [7:0] v, int p);
        for (int r = 0; r < N; r++) begin
            int ch = (p + 1 + r) % N;
            if (v[ch]) return ch;
        end
        return -1;
    endfunction

    function automatic int rank(int ch, int p);
        return (ch - p - 1 + 2 * N) % N;
    endfunction

    task automatic model_reset();
        m_irr = 0; m_isr = 0; m_imr = 0; m_prev = 0; m_vec = 0; m_rdata = 0; m_base = 0;
        m_rsel = 2'b10; m_ptr = N - 1; m_stage = 0; m_gid = N - 1; m_spur = 0;
        m_ltim = 0; m_aeoi = 0; m_rot = 0; m_inta_prev = 1; m_int = 0; m_vv = 0;
    endtask

    task automatic model_step();
        logic [7:0] irq, edges, n_irr, n_isr, wd, set_mask;
        int pend, cur, n_ptr, id, aeoi_clr;
        bit fall, rise, n_rot;
        irq = irq_in; wd = bus_if.wdata[7:0]; id = int'(wd[2:0]);
        fall = m_inta_prev && !bus_if.inta_n;
        rise = !m_inta_prev && bus_if.inta_n;
        edges = irq & ~m_prev;
        pend = top_of(m_irr & ~m_imr, m_ptr);
        cur = top_of(m_isr, m_ptr);
        m_vv = 0;
        if (bus_if.rd_en)
            m_rdata = (bus_if.addr == 2'd1) ? {8'h00, m_imr} :
                      (m_rsel == 2'b11) ? {8'h00, m_isr} : {8'h00, m_irr};
        if (bus_if.wr_en && bus_if.addr == 2'd0) begin
            m_base = wd[7:3]; m_irr = 0; m_isr = 0; m_imr = 0; m_rot = 0;
            m_ptr = N - 1; m_stage = 0; m_int = 0;
        end else begin
            n_irr = m_ltim ? irq : (m_irr | edges);
            n_isr = m_isr; n_ptr = m_ptr; n_rot = m_rot; set_mask = 0; aeoi_clr = -1;
            m_int = (pend >= 0) && (cur < 0 || rank(pend, m_ptr) < rank(cur, m_ptr));
            if (m_stage == 0 && fall) begin
                m_stage = 1; m_int = 0;
                if (pend >= 0) begin
                    m_gid = pend; m_spur = 0; set_mask[pend] = 1'b1;
                    if (!m_ltim && !edges[pend]) n_irr[pend] = 1'b0;
                end else begin
                    m_gid = N - 1; m_spur = 1;
                end
            end else if (m_stage == 1 && fall) begin
                m_stage = 2; m_vv = 1; m_vec = {m_base, 3'(m_gid)};
                if (m_aeoi && !m_spur) aeoi_clr = m_gid;
            end else if (m_stage == 2 && rise) begin
                m_stage = 0;
            end
            if (bus_if.wr_en && bus_if.addr == 2'd2) begin
                case (wd[7:5])
                    3'b001: if (cur >= 0) n_isr[cur] = 0;
                    3'b101: if (cur >= 0) begin n_isr[cur] = 0; n_ptr = cur; end
                    3'b011: n_isr[id] = 0;
                    3'b111: begin n_isr[id] = 0; n_ptr = id; end
                    3'b110: n_ptr = id;
                    3'b100: n_rot = 1;
                    3'b000: n_rot = 0;
                    default: ;
                endcase
            end
            n_isr = n_isr | set_mask;
            if (aeoi_clr >= 0) begin
                n_isr[aeoi_clr] = 0;
                if (m_rot) n_ptr = aeoi_clr;
            end
            if (bus_if.wr_en && bus_if.addr == 2'd1) m_imr = wd;
            if (bus_if.wr_en && bus_if.addr == 2'd3) begin
                m_ltim = wd[0]; m_aeoi = wd[1]; m_rsel = wd[3:2];
            end
            m_irr = n_irr; m_isr = n_isr; m_ptr = n_ptr; m_rot = n_rot;
        end
        m_prev = irq; m_inta_prev = bus_if.inta_n;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    bit mon_en = 0;
    always @(negedge clk) begin
        if (mon_en) begin
            check_val("int_out", bus_if.int_out, m_int);
            check_val("vec_valid", bus_if.vec_valid, m_vv);
            if (m_vv) check_val("vec_out", bus_if.vec_out, m_vec);
            check_val("rdata", bus_if.rdata, m_rdata);
        end
        if (bus_if.vec_valid) begin
            last_vec = bus_if.vec_out;
            vec_cnt++;
        end
    end

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        @(negedge clk); bus_if.wr_en = 1'b1; bus_if.addr = a; bus_if.wdata = d;
        @(negedge clk); bus_if.wr_en = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a);
        @(negedge clk); bus_if.rd_en = 1'b1; bus_if.addr = a;
        @(negedge clk); bus_if.rd_en = 1'b0;
    endtask

    task automatic set_irq(input logic [7:0] v);
        @(negedge clk); irq_in = v;
    endtask

    task automatic pulse();
        @(negedge clk); bus_if.inta_n = 1'b0;
        repeat (2) @(negedge clk);
        bus_if.inta_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    int vc;

    initial begin
        bus_if.wr_en = 0; bus_if.rd_en = 0; bus_if.addr = 0; bus_if.wdata = 0; bus_if.inta_n = 1;
        wait_cyc(3);
        #2 rst_n = 1'b1;
        mon_en = 1;
        wait_cyc(1);
        check_val("rst_int_out", bus_if.int_out, 0);
        check_val("rst_rdata", bus_if.rdata, 0);

        // Fixed priority
        wr(0, 16'h0020); wr(3, 16'h0008);
        set_irq(8'h28); wait_cyc(2);
        check_val("fixed_int_out", bus_if.int_out, 1);
        rd(0); check_val("fixed_irr", bus_if.rdata, 16'h0028);
        pulse(); pulse();
        check_val("fixed_vec", last_vec, 8'h23);
        wr(3, 16'h000C); rd(0);
        check_val("fixed_isr", bus_if.rdata, 16'h0008);
        check_val("lower_blocked", bus_if.int_out, 0);

        // Nesting
        set_irq(8'h68); wait_cyc(2);
        check_val("nest_irq6_blocked", bus_if.int_out, 0);
        wr(2, 16'h0020); wait_cyc(2);
        check_val("nest_after_eoi", bus_if.int_out, 1);
        rd(0); check_val("nest_isr_clear", bus_if.rdata, 0);
        pulse(); pulse();
        check_val("nest_vec5", last_vec, 8'h25);
        check_val("nest_irq6_vs5", bus_if.int_out, 0);
        set_irq(8'h6A); wait_cyc(2);
        check_val("nest_irq1_outranks", bus_if.int_out, 1);

        // Rotation by specific-rotate EOI
        wr(0, 16'h0020); set_irq(8'h00); wait_cyc(2);
        wr(2, 16'h00E3);
        set_irq(8'h18); wait_cyc(2);
        pulse(); pulse();
        check_val("rot_vec4", last_vec, 8'h24);

        // AEOI with rotate-on-AEOI
        wr(0, 16'h0020); set_irq(8'h00);
        wr(3, 16'h000E); wr(2, 16'h0080);
        set_irq(8'h04); wait_cyc(2);
        pulse(); pulse();
        check_val("aeoi_vec2", last_vec, 8'h22);
        rd(0); check_val("aeoi_isr_empty", bus_if.rdata, 0);
        set_irq(8'h0E); wait_cyc(2);
        pulse(); pulse();
        check_val("aeoi_rot_vec3", last_vec, 8'h23);

        // Mask and level mode
        wr(0, 16'h0020); wr(3, 16'h0009); wr(1, 16'h0001);
        set_irq(8'h01); wait_cyc(2);
        check_val("masked_int_out", bus_if.int_out, 0);
        rd(0); check_val("level_irr_set", bus_if.rdata, 16'h0001);
        set_irq(8'h00);
        rd(0); check_val("level_irr_drop", bus_if.rdata, 0);

        // Spurious acknowledge
        wr(0, 16'h0020); wr(1, 16'h0000); wr(3, 16'h000C);
        set_irq(8'h00); wait_cyc(2);
        pulse(); pulse();
        check_val("spurious_vec", last_vec, 8'h27);
        rd(0); check_val("spurious_isr", bus_if.rdata, 0);

        // Reset while in ACK1
        vc = vec_cnt;
        pulse();
        @(negedge clk); #2 rst_n = 1'b0;
        @(negedge clk);
        check_val("rst_ack1_int_out", bus_if.int_out, 0);
        check_val("rst_ack1_rdata", bus_if.rdata, 0);
        #2 rst_n = 1'b1;
        pulse(); wait_cyc(2);
        check_val("rst_ack1_no_vec", vec_cnt, vc);
        pulse(); wait_cyc(1);
        check_val("rst_ack1_vec_cnt", vec_cnt, vc + 1);
        check_val("rst_ack1_vec", last_vec, 8'h07);

        // Random traffic against the model
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if ($urandom_range(3) == 0) irq_in = irq_in ^ (8'h01 << $urandom_range(7));
            bus_if.wr_en = ($urandom_range(5) == 0);
            bus_if.addr  = 2'($urandom_range(3));
            if (bus_if.addr == 2'd0 && $urandom_range(7) != 0) bus_if.addr = 2'd2;
            bus_if.wdata = 16'($urandom);
            bus_if.rd_en = ($urandom_range(3) == 0);
            if ($urandom_range(4) == 0) bus_if.inta_n = ~bus_if.inta_n;
        end
        @(negedge clk);
        bus_if.wr_en = 0; bus_if.rd_en = 0; bus_if.inta_n = 1;
        wait_cyc(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
